rr_arb_mux: RTL

- Parametrised, registered N-channel W-bit arbitrating multiplexer with valid/ready handshakes on every input and on the output.
- Successor to the combinational mux2to1/mux4to1/mux16to1 tree: select is generated internally by round-robin arbitration instead of being driven externally.
- Adds a per-channel lock for multi-beat bus transfers.
- Sits in front of the shared internal data bus. It replaces the tristate-driven bus sharing for multiple masters (fetch, load/store, I/O).

---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 47 ++++
 rtl/rr_arb_mux.sv | 104 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbitrating mux.
package arb_pkg;

  // Arbiter mode: free round-robin, or pinned to one channel mid-sequence.
  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Largest supported channel count.
  localparam int N_MAX = 16;

  // Index width for n channels, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate requests so the channel after
// the last grant sits at bit 0, take the lowest set bit, rotate back.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = clog2_min1(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_last_grant,
  output logic [N-1:0]  o_grant,
  output logic [SW-1:0] o_grant_idx,
  output logic          o_any
);

  logic [N-1:0] w_rot;
  int           w_start;
  int           w_k;
  int           w_idx;
  logic         w_found;

  // Rotate, fixed-priority search, rotate the winner back to a channel index.
  always_comb begin
    w_rot   = '0;
    w_k     = 0;
    w_idx   = 0;
    w_found = 1'b0;
    w_start = (int'(i_last_grant) >= N - 1) ? 0 : int'(i_last_grant) + 1;
    for (int i = 0; i < N; i++) begin
      w_idx = i + w_start;
      if (w_idx >= N) w_idx = w_idx - N;
      w_rot[i] = i_req[w_idx];
    end
    for (int i = 0; i < N; i++) begin
      if (w_rot[i] && !w_found) begin
        w_found = 1'b1;
        w_k     = i;
      end
    end
    w_idx = w_k + w_start;
    if (w_idx >= N) w_idx = w_idx - N;
    o_any       = w_found;
    o_grant_idx = SW'(w_idx);
    o_grant     = w_found ? (N'(1) << w_idx) : '0;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Registered N-channel arbitrating mux with round-robin grant and
// per-channel lock for multi-beat transfers.
//
// Handshake: a beat moves on any port when valid and ready are both 1 at a
// rising edge. in_ready is computed from in_valid, state and out_ready only,
// never from in_ready itself; out_valid never depends on out_ready.
module rr_arb_mux
  import arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int LOCK_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N*W-1:0]           in_data,
  input  logic [N-1:0]             in_valid,
  input  logic [N-1:0]             in_lock,
  output logic [N-1:0]             in_ready,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [clog2_min1(N)-1:0] out_sel,
  output logic                     out_last,
  output logic                     o_dbg_state
);

  localparam int SW = clog2_min1(N);

  state_e        r_state;
  logic [SW-1:0] r_lock_ch;
  logic [SW-1:0] r_last_grant;
  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic [SW-1:0] r_out_sel;
  logic          r_out_last;

  logic          w_can_take;
  logic [N-1:0]  w_pick_oh;
  logic [SW-1:0] w_pick_idx;
  logic          w_pick_any;
  logic [N-1:0]  w_ready;
  logic [SW-1:0] w_sel;
  logic          w_fire;
  logic          w_lock_beat;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .i_req        (in_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick_oh),
    .o_grant_idx  (w_pick_idx),
    .o_any        (w_pick_any)
  );

  // Grant selection: round-robin in ARB, the pinned channel while LOCKED.
  always_comb begin
    w_can_take = !r_out_valid || out_ready;
    w_ready    = '0;
    w_sel      = w_pick_idx;
    if (r_state == ST_LOCKED) begin
      w_sel = r_lock_ch;
      if (w_can_take) w_ready = N'(1) << r_lock_ch;
    end else if (w_can_take && w_pick_any) begin
      w_ready = w_pick_oh;
    end
    w_fire      = |(w_ready & in_valid);
    w_lock_beat = (LOCK_EN != 0) && in_lock[w_sel];
  end

  // Output register, grant pointer and lock FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_ARB;
      r_lock_ch    <= '0;
      r_last_grant <= SW'(N - 1);
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_sel    <= '0;
      r_out_last   <= 1'b0;
    end else if (w_fire) begin
      r_out_data   <= in_data[int'(w_sel)*W +: W];
      r_out_sel    <= w_sel;
      r_out_valid  <= 1'b1;
      r_out_last   <= !w_lock_beat;
      r_last_grant <= w_sel;
      if (w_lock_beat) begin
        r_state   <= ST_LOCKED;
        r_lock_ch <= w_sel;
      end else begin
        r_state   <= ST_ARB;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready    = w_ready;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_sel     = r_out_sel;
  assign out_last    = r_out_last;
  assign o_dbg_state = r_state;

endmodule
